// File: rtl/aes_pkg.sv
// Shared AES widths and the CTR controller state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        KICK   = 3'd2,
        WAIT   = 3'd3,
        KS_RDY = 3'd4
    } state_t;

endpackage

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencer: builds counter blocks for an external encipher core and
// XORs the returned keystream onto a 128-bit payload stream.
module aes_ctr_ctrl
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AES_KEY_W-1:0]             s_key,
    input  logic [AES_BLOCK_W-CTR_WIDTH-1:0] s_nonce,
    input  logic [CTR_WIDTH-1:0]             s_ctr_init,
    input  logic                             s_start,
    output logic                             idle,
    input  logic [AES_BLOCK_W-1:0]           s_data,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [AES_BLOCK_W-1:0]           m_data,
    output logic                             m_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [AES_KEY_W-1:0]             enc_key,
    output logic [AES_BLOCK_W-1:0]           enc_block,
    output logic                             enc_valid,
    input  logic                             enc_ready,
    input  logic [AES_BLOCK_W-1:0]           enc_result,
    output logic                             err_wrap
);

    localparam int NONCE_W = AES_BLOCK_W - CTR_WIDTH;

    state_t                 state;
    logic [AES_KEY_W-1:0]   key_q;
    logic [NONCE_W-1:0]     nonce_q;
    logic [CTR_WIDTH-1:0]   ctr_q;
    logic [AES_BLOCK_W-1:0] keystream;
    logic                   wait_first;
    logic                   accept;

    assign s_ready   = (state == KS_RDY) && (!m_valid || m_ready);
    assign accept    = s_valid && s_ready;
    assign enc_key   = key_q;
    assign enc_block = {nonce_q, ctr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idle       <= 1'b1;
            key_q      <= '0;
            nonce_q    <= '0;
            ctr_q      <= '0;
            keystream  <= '0;
            wait_first <= 1'b0;
            enc_valid  <= 1'b0;
            err_wrap   <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            // Output register: a new accept overrides a drain so there is no bubble.
            if (accept) begin
                m_data  <= s_data ^ keystream;
                m_last  <= s_last;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s_start) begin
                        key_q    <= s_key;
                        nonce_q  <= s_nonce;
                        ctr_q    <= s_ctr_init;
                        err_wrap <= 1'b0;
                        idle     <= 1'b0;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (enc_ready) begin
                        enc_valid <= 1'b1;
                        state     <= KICK;
                    end
                end
                KICK: begin
                    enc_valid  <= 1'b0;
                    wait_first <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    // The core may still show the stale ready on the first cycle.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (enc_ready) begin
                        keystream <= enc_result;
                        state     <= KS_RDY;
                    end
                end
                KS_RDY: begin
                    if (accept) begin
                        ctr_q <= ctr_q + CTR_WIDTH'(1);
                        if (s_last) begin
                            idle  <= 1'b1;
                            state <= IDLE;
                        end else if (&ctr_q) begin
                            err_wrap <= 1'b1;
                            idle     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end
                default: begin
                    enc_valid <= 1'b0;
                    idle      <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Scoreboard bench for aes_ctr_ctrl with a behavioural encipher core stand-in.
module tb_aes_ctr_ctrl;

    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [95:0]  N0   = 96'h00112233445566778899aabb;
    localparam logic [31:0]  C0   = 32'hccddeeff;
    localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] s_key = '0;
    logic [95:0]  s_nonce = '0;
    logic [31:0]  s_ctr_init = '0;
    logic         s_start = 1'b0;
    logic         idle;
    logic [127:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [127:0] enc_key;
    logic [127:0] enc_block;
    logic         enc_valid;
    logic         enc_ready;
    logic [127:0] enc_result;
    logic         err_wrap;

    aes_ctr_ctrl #(.CTR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s_key(s_key), .s_nonce(s_nonce), .s_ctr_init(s_ctr_init),
        .s_start(s_start), .idle(idle), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .enc_key(enc_key), .enc_block(enc_block), .enc_valid(enc_valid),
        .enc_ready(enc_ready), .enc_result(enc_result), .err_wrap(err_wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;
    exp_t exp_q[$];

    // Core stand-in: the FIPS-197 vector for the reference block, otherwise a keyed scramble.
    function automatic logic [127:0] fake_enc(input logic [127:0] k, input logic [127:0] b);
        if (k == K0 && b == {N0, C0}) return FIPS;
        return {b[63:0] ^ k[127:64], b[127:64] ^ k[63:0]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
    endfunction

    int           core_lat = 6;
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    logic [127:0] core_res = '0;
    logic [127:0] last_kick = '0;
    int           proto_err = 0;

    assign enc_ready  = !core_busy && !enc_valid;
    assign enc_result = core_res;

    always @(posedge clk) begin
        if (enc_valid) begin
            if (core_busy) proto_err++;
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            core_res  <= fake_enc(enc_key, enc_block);
            last_kick <= enc_block;
        end else if (core_busy) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            else core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h, required no output", m_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_data", m_data, e.data);
                check("m_last", {127'd0, m_last}, {127'd0, e.last});
            end
        end
    end

    logic [127:0] cur_key;
    logic [95:0]  cur_nonce;
    logic [31:0]  cur_ctr;

    task automatic start_session(input logic [127:0] k, input logic [95:0] n, input logic [31:0] c);
        @(posedge clk); #1;
        s_key = k; s_nonce = n; s_ctr_init = c; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cur_key = k; cur_nonce = n; cur_ctr = c;
    endtask

    task automatic send_block(input logic [127:0] d, input logic l, input logic [127:0] exp_data);
        int n;
        exp_t e;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_last = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got s_ready=0, required 1");
            s_valid = 1'b0;
            return;
        end
        e.data = exp_data;
        e.last = l;
        exp_q.push_back(e);
        cur_ctr = cur_ctr + 32'd1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        check("m_valid_after_accept", {127'd0, m_valid}, 128'd1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((!idle || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, {127'd0, idle}, 128'd1);
        check({name, "_drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] hold_data;
        logic         hold_last;
        logic [127:0] hold_blk;
        int           bad_data, bad_last, bad_rdy, bad_blk, n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_idle", {127'd0, idle}, 128'd1);
        check("rst_m_valid", {127'd0, m_valid}, 128'd0);
        check("rst_m_data", m_data, 128'd0);
        check("rst_enc_valid", {127'd0, enc_valid}, 128'd0);
        check("rst_err_wrap", {127'd0, err_wrap}, 128'd0);
        check("rst_s_ready", {127'd0, s_ready}, 128'd0);

        // Single-block session against the FIPS-197 vector.
        start_session(K0, N0, C0);
        check("start_idle_low", {127'd0, idle}, 128'd0);
        send_block(128'd0, 1'b1, FIPS);
        check("kick_block", last_kick, {N0, C0});
        wait_done("single_idle");

        // Two blocks: counter increments into the low byte carry.
        d1 = 128'h0123456789abcdef_fedcba9876543210;
        start_session(K0, N0, C0);
        send_block(d1, 1'b0, FIPS ^ d1);
        send_block(FIPS, 1'b1, fake_enc(K0, {N0, 32'hccddef00}) ^ FIPS);
        check("kick2_block", last_kick, {N0, 32'hccddef00});
        wait_done("two_idle");

        // Counter wrap aborts the session with a sticky error.
        start_session(K0, N0, 32'hffffffff);
        send_block(d1, 1'b0, fake_enc(K0, {N0, 32'hffffffff}) ^ d1);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = FIPS; s_last = 1'b1;
        bad_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_ready) bad_rdy++;
        end
        check("wrap_err", {127'd0, err_wrap}, 128'd1);
        check("wrap_idle", {127'd0, idle}, 128'd1);
        check("wrap_no_ready", 128'(bad_rdy), 128'd0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        start_session(K0, N0, 32'h00000005);
        check("wrap_cleared", {127'd0, err_wrap}, 128'd0);
        send_block(d1, 1'b1, fake_enc(K0, {N0, 32'h00000005}) ^ d1);
        wait_done("wrap_restart_idle");

        // Output back-pressure: result holds, input stalls, counter frozen.
        @(posedge clk); #1 m_ready = 1'b0;
        start_session(K0, N0, 32'h00000010);
        send_block(d1, 1'b0, fake_enc(K0, {N0, 32'h00000010}) ^ d1);
        @(negedge clk);
        hold_data = m_data; hold_last = m_last; hold_blk = enc_block;
        bad_data = 0; bad_last = 0; bad_rdy = 0; bad_blk = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_data !== hold_data) bad_data++;
            if (m_last !== hold_last) bad_last++;
            if (s_ready) bad_rdy++;
            if (enc_block !== hold_blk) bad_blk++;
        end
        check("bp_hold_block", hold_blk, {N0, 32'h00000011});
        check("bp_m_data_stable", 128'(bad_data), 128'd0);
        check("bp_m_last_stable", 128'(bad_last), 128'd0);
        check("bp_s_ready_low", 128'(bad_rdy), 128'd0);
        check("bp_ctr_stable", 128'(bad_blk), 128'd0);
        check("bp_m_valid", {127'd0, m_valid}, 128'd1);
        fork
            begin @(posedge clk); #1 m_ready = 1'b1; end
            send_block(FIPS, 1'b1, fake_enc(K0, {N0, 32'h00000011}) ^ FIPS);
        join
        wait_done("bp_idle");

        // Reset while the core is busy: new session must wait for the core.
        core_lat = 14;
        start_session(d1, N0, 32'h00000077);
        n = 0;
        while (!enc_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_kick", {127'd0, enc_valid}, 128'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", {127'd0, idle}, 128'd1);
        core_lat = 6;
        start_session(K0, N0, C0);
        repeat (2) @(negedge clk);
        check("sync_hold_enc_valid", {127'd0, enc_valid}, 128'd0);
        send_block(128'd0, 1'b1, FIPS);
        wait_done("rst_restart_idle");

        // Start request while a session is active is ignored.
        start_session(K0, N0, C0);
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        s_key = ~K0; s_nonce = ~N0; s_ctr_init = 32'h12345678; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(negedge clk);
        check("ign_start_key", enc_key, K0);
        check("ign_start_block", enc_block, {N0, C0});
        check("ign_start_idle", {127'd0, idle}, 128'd0);
        send_block(128'd0, 1'b1, FIPS);
        wait_done("ign_start_done");

        check("core_protocol", 128'(proto_err), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no completion, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
